ped_crossing_ctrl: RTL and testbench
====================================

PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

Interface
REQ-001 SHALL have parameter WALK_CYCLES, default 8, number of cycles walk is held (legal 1..15).
REQ-002 SHALL have parameter CLEAR_CYCLES, default 6, number of cycles of the flashing-clearance phase (legal 1..15).
REQ-003 SHALL have parameter FLASH_DIV, default 2, cycles per dont_walk toggle in clearance (legal 1..15).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 veh_red, veh_yellow, veh_green  input  1 each  vehicle lamp states from the upstream traffic signal, synchronous to clk.
REQ-007 ped_button  input  1  crossing request, already synchronised and debounced, level-sampled each cycle.
REQ-008 walk  output  1  WALK lamp.
REQ-009 dont_walk  output  1  DON'T WALK lamp, steady or flashing.
REQ-010 countdown  output  4  clearance cycles remaining, 0 outside CLEAR.
REQ-011 req_pending  output  1  request latched, not yet served.
REQ-012 fault  output  1  vehicle lamp inputs not one-hot.

Function
REQ-013 All outputs SHALL be registered; each output SHALL reflect the state entered on the same clock edge.
REQ-014 States: IDLE, WAIT, WALK, CLEAR, FAULT.
REQ-015 red_rise = veh_red AND NOT red_q, where red_q is veh_red registered one cycle.
REQ-016 IDLE: walk=0, dont_walk=1, countdown=0; ped_button=1 -> WAIT, unless red_rise is high in the same cycle, in which case -> WALK directly.
REQ-017 WAIT: req_pending=1, dont_walk=1; red_rise -> WALK.
REQ-018 WALK: walk=1, dont_walk=0 for exactly WALK_CYCLES cycles, then -> CLEAR; req_pending cleared on entry; ped_button ignored.
REQ-019 CLEAR: walk=0 for exactly CLEAR_CYCLES cycles.
REQ-020 CLEAR countdown: shows CLEAR_CYCLES-1 on the first cycle, decrements by 1 per cycle, and shows 0 on the last cycle.
REQ-021 CLEAR dont_walk: 1 on the first cycle, inverted every FLASH_DIV cycles thereafter.
REQ-022 CLEAR exit: -> WAIT if req_pending=1, else -> IDLE.
REQ-023 ped_button=1 during CLEAR SHALL set req_pending, so the next request is queued.
REQ-024 Abort: veh_green=1 while in WALK or CLEAR -> IDLE next cycle (walk=0, dont_walk=1, countdown=0); req_pending is retained, and the next state is WAIT if it is set.
REQ-025 Fault: lamp inputs not exactly one-hot (including all-zero), in any state -> FAULT next cycle; fault has priority over every other transition.
REQ-026 FAULT outputs: fault=1, walk=0, dont_walk=1 steady, countdown=0, req_pending=0.
REQ-027 FAULT exit: one-hot inputs for 2 consecutive cycles -> IDLE.
REQ-028 walk and dont_walk SHALL never both be 1 in the same cycle.
REQ-029 Counters SHALL be 4-bit unsigned with no wrap: load on state entry, stop at 0.

Reset
REQ-030 On reset: state=IDLE, walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0, red_q=1.
REQ-031 Setting red_q=1 on reset prevents a spurious red_rise on the first cycle after reset.
REQ-032 Reset mid-WALK or mid-CLEAR SHALL take effect on the next edge; any pending request is discarded.

Structure
REQ-033 Package ped_pkg SHALL hold the state enum (5 states, 3-bit encoding) and the default values of WALK_CYCLES, CLEAR_CYCLES and FLASH_DIV.
REQ-034 Sub-module ped_phase_timer SHALL provide the 4-bit loadable down-counter with a zero flag, plus the FLASH_DIV toggle generator; instantiated once.

Verification
REQ-035 Serve on red: button pulsed in IDLE, red rises 3 cycles later -> req_pending=1 for 3 cycles, then walk=1 for 8 cycles, then countdown 5,4,3,2,1,0 with dont_walk 1,1,0,0,1,1, then IDLE.
REQ-036 Simultaneous request and red: button and red_rise in the same cycle -> walk=1 on the next cycle, and req_pending is never observed high.
REQ-037 Queued request: button pressed in the 3rd CLEAR cycle -> CLEAR exits to WAIT, and WALK starts again on the next red_rise.
REQ-038 Green abort: veh_green=1 in the 4th WALK cycle -> walk=0, dont_walk=1 on the next cycle, state IDLE.
REQ-039 Fault: veh_red=veh_green=1 for 1 cycle during WALK -> fault=1 and walk=0 on the next cycle; fault clears 2 cycles after inputs return to one-hot.
REQ-040 Reset mid-CLEAR at countdown=3 -> next cycle: countdown=0, dont_walk=1, req_pending=0, state IDLE.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian crossing controller: state encoding,
// default phase lengths and a lamp-sanity helper.
package ped_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WALK  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_FAULT = 3'd4
    } ped_state_e;

    localparam int unsigned DEF_WALK_CYCLES  = 8;
    localparam int unsigned DEF_CLEAR_CYCLES = 6;
    localparam int unsigned DEF_FLASH_DIV    = 2;

    // True when exactly one of the three vehicle lamps is lit.
    function automatic logic is_one_hot3(input logic a, input logic b, input logic c);
        return (a ^ b ^ c) & ~(a & b & c);
    endfunction

endpackage

// File: rtl/ped_phase_timer.sv
// Phase timer for the crossing controller: a loadable 4-bit down-counter that
// parks at zero, plus the flash toggle used for the clearance DON'T WALK lamp.
// The next-cycle values are exported so the controller can register its
// outputs in step with the counter registers.
module ped_phase_timer
    import ped_pkg::*;
#(
    parameter int unsigned FLASH_DIV = DEF_FLASH_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    input  logic       i_flash_start,
    input  logic       i_flash_run,
    output logic       o_zero,
    output logic [3:0] o_count_nxt,
    output logic       o_flash_nxt
);

    localparam logic [3:0] LP_FLASH_RELOAD = 4'(FLASH_DIV - 1);

    logic [3:0] r_count;
    logic [3:0] r_fcnt;
    logic       r_flash;
    logic [3:0] w_count_nxt;
    logic [3:0] w_fcnt_nxt;
    logic       w_flash_nxt;

    // Down-counter next value: load wins, otherwise decrement and stick at zero.
    always_comb begin
        w_count_nxt = r_count;
        if (i_load) begin
            w_count_nxt = i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            w_count_nxt = r_count - 4'd1;
        end
    end

    // Flash generator: lamp starts lit and inverts each time the divider expires.
    always_comb begin
        w_fcnt_nxt  = r_fcnt;
        w_flash_nxt = r_flash;
        if (i_flash_start) begin
            w_fcnt_nxt  = LP_FLASH_RELOAD;
            w_flash_nxt = 1'b1;
        end else if (i_flash_run) begin
            if (r_fcnt == 4'd0) begin
                w_fcnt_nxt  = LP_FLASH_RELOAD;
                w_flash_nxt = ~r_flash;
            end else begin
                w_fcnt_nxt = r_fcnt - 4'd1;
            end
        end
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 4'd0;
            r_fcnt  <= 4'd0;
            r_flash <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_flash <= w_flash_nxt;
        end
    end

    assign o_zero      = (r_count == 4'd0);
    assign o_count_nxt = w_count_nxt;
    assign o_flash_nxt = w_flash_nxt;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller. Latches a crossing request, grants WALK on
// the rising edge of the vehicle red lamp, runs a flashing clearance phase,
// aborts if vehicles get green, and locks into FAULT on inconsistent lamps.
//
// state | meaning
// IDLE  | no request, steady DON'T WALK
// WAIT  | request latched, waiting for vehicle red to rise
// WALK  | WALK lamp on for WALK_CYCLES
// CLEAR | flashing DON'T WALK with countdown for CLEAR_CYCLES
// FAULT | vehicle lamps not one-hot; needs two clean cycles to leave
module ped_crossing_ctrl
    import ped_pkg::*;
#(
    parameter int unsigned WALK_CYCLES  = DEF_WALK_CYCLES,
    parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int unsigned FLASH_DIV    = DEF_FLASH_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_veh_red,
    input  logic       i_veh_yellow,
    input  logic       i_veh_green,
    input  logic       i_ped_button,
    output logic       o_walk,
    output logic       o_dont_walk,
    output logic [3:0] o_countdown,
    output logic       o_req_pending,
    output logic       o_fault
);

    localparam logic [3:0] LP_WALK_LOAD  = 4'(WALK_CYCLES - 1);
    localparam logic [3:0] LP_CLEAR_LOAD = 4'(CLEAR_CYCLES - 1);

    ped_state_e r_state;
    logic       r_red_q;
    logic       r_ok_cnt;
    logic       r_req;
    logic       r_walk;
    logic       r_dont_walk;
    logic [3:0] r_countdown;
    logic       r_fault;

    ped_state_e w_state_nxt;
    logic       w_one_hot;
    logic       w_red_rise;
    logic       w_req_nxt;
    logic       w_ok_nxt;
    logic       w_load;
    logic [3:0] w_load_val;
    logic       w_dec;
    logic       w_flash_start;
    logic       w_flash_run;
    logic       w_zero;
    logic [3:0] w_count_nxt;
    logic       w_flash_nxt;
    logic       w_walk_nxt;
    logic       w_dont_walk_nxt;
    logic [3:0] w_countdown_nxt;
    logic       w_fault_nxt;

    assign w_one_hot  = is_one_hot3(i_veh_red, i_veh_yellow, i_veh_green);
    assign w_red_rise = i_veh_red & ~r_red_q;

    ped_phase_timer #(
        .FLASH_DIV (FLASH_DIV)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_load),
        .i_load_val    (w_load_val),
        .i_dec         (w_dec),
        .i_flash_start (w_flash_start),
        .i_flash_run   (w_flash_run),
        .o_zero        (w_zero),
        .o_count_nxt   (w_count_nxt),
        .o_flash_nxt   (w_flash_nxt)
    );

    // State, request latch and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_red_q     <= 1'b1;
            r_ok_cnt    <= 1'b0;
            r_req       <= 1'b0;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_countdown <= 4'd0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_red_q     <= i_veh_red;
            r_ok_cnt    <= w_ok_nxt;
            r_req       <= w_req_nxt;
            r_walk      <= w_walk_nxt;
            r_dont_walk <= w_dont_walk_nxt;
            r_countdown <= w_countdown_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    // Next state, request bookkeeping and timer control; lamp fault overrides all.
    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_ok_nxt      = 1'b0;
        w_load        = 1'b0;
        w_load_val    = 4'd0;
        w_dec         = 1'b0;
        w_flash_start = 1'b0;
        w_flash_run   = 1'b0;
        if (!w_one_hot) begin
            w_state_nxt = ST_FAULT;
            w_req_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ped_button && w_red_rise) begin
                        w_state_nxt = ST_WALK;
                        w_req_nxt   = 1'b0;
                        w_load      = 1'b1;
                        w_load_val  = LP_WALK_LOAD;
                    end else if (i_ped_button || r_req) begin
                        w_state_nxt = ST_WAIT;
                        w_req_nxt   = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_red_rise) begin
                        w_state_nxt = ST_WALK;
                        w_req_nxt   = 1'b0;
                        w_load      = 1'b1;
                        w_load_val  = LP_WALK_LOAD;
                    end
                end
                ST_WALK: begin
                    if (i_veh_green) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_zero) begin
                        w_state_nxt   = ST_CLEAR;
                        w_load        = 1'b1;
                        w_load_val    = LP_CLEAR_LOAD;
                        w_flash_start = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // A press on the final clearance cycle still queues the next crossing.
                    w_req_nxt = r_req | i_ped_button;
                    if (i_veh_green) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_zero) begin
                        w_state_nxt = w_req_nxt ? ST_WAIT : ST_IDLE;
                    end else begin
                        w_dec       = 1'b1;
                        w_flash_run = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (r_ok_cnt) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ok_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Lamp values for the state being entered, so outputs change with the state.
    always_comb begin
        w_walk_nxt      = 1'b0;
        w_dont_walk_nxt = 1'b1;
        w_countdown_nxt = 4'd0;
        w_fault_nxt     = 1'b0;
        case (w_state_nxt)
            ST_WALK: begin
                w_walk_nxt      = 1'b1;
                w_dont_walk_nxt = 1'b0;
            end
            ST_CLEAR: begin
                w_dont_walk_nxt = w_flash_nxt;
                w_countdown_nxt = w_count_nxt;
            end
            ST_FAULT: begin
                w_fault_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_walk        = r_walk;
    assign o_dont_walk   = r_dont_walk;
    assign o_countdown   = r_countdown;
    assign o_req_pending = r_req;
    assign o_fault       = r_fault;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed scenarios with literal expectations,
// a cycle-level behavioural model compared on every cycle, and a short
// pseudo-random tail.
module tb_ped_crossing_ctrl;

    localparam int WC = 8;
    localparam int CC = 6;
    localparam int FD = 2;

    localparam logic [3:0] R = 4'b1000;
    localparam logic [3:0] Y = 4'b0100;
    localparam logic [3:0] G = 4'b0010;
    localparam logic [3:0] B = 4'b0001;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_WALK  = 2;
    localparam int P_CLEAR = 3;
    localparam int P_FAULT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       red = 1'b0;
    logic       yel = 1'b0;
    logic       grn = 1'b1;
    logic       btn = 1'b0;
    logic       o_walk;
    logic       o_dont_walk;
    logic [3:0] o_countdown;
    logic       o_req_pending;
    logic       o_fault;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // model: phase, cycles elapsed in phase, request latch, clean-cycle count
    int m_phase = P_IDLE;
    int m_k     = 0;
    int m_okc   = 0;
    bit m_req   = 1'b0;
    bit m_red_q = 1'b1;
    bit m_oh;
    bit m_rise;

    always #5 clk = ~clk;

    ped_crossing_ctrl #(
        .WALK_CYCLES  (WC),
        .CLEAR_CYCLES (CC),
        .FLASH_DIV    (FD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_veh_red     (red),
        .i_veh_yellow  (yel),
        .i_veh_green   (grn),
        .i_ped_button  (btn),
        .o_walk        (o_walk),
        .o_dont_walk   (o_dont_walk),
        .o_countdown   (o_countdown),
        .o_req_pending (o_req_pending),
        .o_fault       (o_fault)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Advance the model by one clock using the inputs sampled at this edge.
    task model_step();
        m_oh   = (int'(red) + int'(yel) + int'(grn)) == 1;
        m_rise = red && !m_red_q;
        m_red_q = red;
        if (reset) begin
            m_phase = P_IDLE; m_req = 0; m_k = 0; m_okc = 0; m_red_q = 1;
        end else if (!m_oh) begin
            m_phase = P_FAULT; m_req = 0; m_okc = 0;
        end else begin
            case (m_phase)
                P_FAULT: begin
                    m_okc++;
                    if (m_okc == 2) begin m_phase = P_IDLE; m_okc = 0; end
                end
                P_IDLE: begin
                    if (btn && m_rise) begin m_phase = P_WALK; m_k = 0; m_req = 0; end
                    else if (btn || m_req) begin m_phase = P_WAIT; m_req = 1; end
                end
                P_WAIT: begin
                    if (m_rise) begin m_phase = P_WALK; m_k = 0; m_req = 0; end
                end
                P_WALK: begin
                    if (grn) m_phase = P_IDLE;
                    else if (m_k == WC - 1) begin m_phase = P_CLEAR; m_k = 0; end
                    else m_k++;
                end
                default: begin
                    if (btn) m_req = 1;
                    if (grn) m_phase = P_IDLE;
                    else if (m_k == CC - 1) m_phase = m_req ? P_WAIT : P_IDLE;
                    else m_k++;
                end
            endcase
        end
    endtask

    task cyc(input logic [3:0] v);
        {red, yel, grn, btn} = v;
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("walk", int'(o_walk), int'(m_phase == P_WALK));
            chk("dont_walk", int'(o_dont_walk),
                (m_phase == P_CLEAR) ? int'(((m_k / FD) % 2) == 0) : int'(m_phase != P_WALK));
            chk("countdown", int'(o_countdown), (m_phase == P_CLEAR) ? (CC - 1 - m_k) : 0);
            chk("req_pending", int'(o_req_pending), int'(m_req));
            chk("fault", int'(o_fault), int'(m_phase == P_FAULT));
            chk("walk_dw_excl", int'(o_walk && o_dont_walk), 0);
        end
    end

    initial begin
        int exp_cd[6] = '{5, 4, 3, 2, 1, 0};
        int exp_dw[6] = '{1, 1, 0, 0, 1, 1};
        int n_walk;
        int seen_req;
        int lamp;
        logic [3:0] v;

        reset = 1'b1;
        cyc(G);
        cmp_en = 1'b1;
        cyc(G);
        chk("rst_walk", int'(o_walk), 0);
        chk("rst_dw", int'(o_dont_walk), 1);
        chk("rst_cd", int'(o_countdown), 0);
        chk("rst_req", int'(o_req_pending), 0);
        chk("rst_fault", int'(o_fault), 0);
        reset = 1'b0;

        // serve on red
        cyc(G); cyc(G);
        cyc(G | B);
        chk("s1_req_btn", int'(o_req_pending), 1);
        cyc(Y); cyc(Y);
        chk("s1_req_wait", int'(o_req_pending), 1);
        cyc(R);
        chk("s1_walk_on", int'(o_walk), 1);
        chk("s1_req_clr", int'(o_req_pending), 0);
        n_walk = 1;
        for (int i = 0; i < 7; i++) begin
            cyc(R);
            n_walk += int'(o_walk);
        end
        chk("s1_walk_len", n_walk, 8);
        for (int i = 0; i < 6; i++) begin
            cyc(R);
            chk("s1_clr_cd", int'(o_countdown), exp_cd[i]);
            chk("s1_clr_dw", int'(o_dont_walk), exp_dw[i]);
        end
        cyc(R);
        chk("s1_idle_walk", int'(o_walk), 0);
        chk("s1_idle_dw", int'(o_dont_walk), 1);

        // simultaneous request and red rise, then a queued request
        cyc(G);
        cyc(R | B);
        chk("s2_walk_next", int'(o_walk), 1);
        seen_req = int'(o_req_pending);
        for (int i = 0; i < 10; i++) begin
            cyc(R);
            seen_req |= int'(o_req_pending);
        end
        chk("s2_no_req", seen_req, 0);
        chk("s2_cd3", int'(o_countdown), 3);
        cyc(R | B);
        chk("s3_queued", int'(o_req_pending), 1);
        cyc(R); cyc(R);
        chk("s3_cd0", int'(o_countdown), 0);
        cyc(R);
        chk("s3_wait_walk", int'(o_walk), 0);
        chk("s3_wait_req", int'(o_req_pending), 1);
        cyc(G); cyc(Y);
        cyc(R);
        chk("s3_rewalk", int'(o_walk), 1);

        // green abort in 4th walk cycle
        cyc(R); cyc(R); cyc(R);
        cyc(G);
        chk("s4_abort_walk", int'(o_walk), 0);
        chk("s4_abort_dw", int'(o_dont_walk), 1);
        chk("s4_abort_cd", int'(o_countdown), 0);

        // abort in clearance keeps the queued request
        cyc(R | B);
        for (int i = 0; i < 8; i++) cyc(R);
        cyc(R | B);
        cyc(G);
        chk("s5_abort_req", int'(o_req_pending), 1);
        chk("s5_abort_cd", int'(o_countdown), 0);
        cyc(G); cyc(Y);
        cyc(R);
        chk("s5_walk", int'(o_walk), 1);

        // lamp faults
        cyc(R); cyc(R);
        cyc(R | G);
        chk("s6_fault", int'(o_fault), 1);
        chk("s6_fault_walk", int'(o_walk), 0);
        cyc(R);
        chk("s6_fault_hold", int'(o_fault), 1);
        cyc(R);
        chk("s6_fault_clr", int'(o_fault), 0);
        cyc(4'b0000);
        chk("s6_zero_fault", int'(o_fault), 1);
        cyc(G); cyc(G);
        chk("s6_zero_clr", int'(o_fault), 0);

        // reset mid-clearance discards request; red held through reset is no rise
        cyc(R | B);
        for (int i = 0; i < 8; i++) cyc(R);
        cyc(R | B);
        cyc(R);
        chk("s7_cd3", int'(o_countdown), 3);
        reset = 1'b1;
        cyc(R);
        chk("s7_rst_cd", int'(o_countdown), 0);
        chk("s7_rst_dw", int'(o_dont_walk), 1);
        chk("s7_rst_req", int'(o_req_pending), 0);
        reset = 1'b0;
        cyc(R | B);
        chk("s7_no_rise", int'(o_walk), 0);
        cyc(G);

        // pseudo-random tail checked by the model
        lamp = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) lamp = $urandom_range(2);
            v = 4'b0000;
            v[3 - lamp] = 1'b1;
            if ($urandom_range(24) == 0) v[3:1] = 3'($urandom_range(7));
            v[0] = ($urandom_range(7) == 0);
            reset = ($urandom_range(149) == 0);
            cyc(v);
        end
        reset = 1'b0;
        cyc(G);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
